// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline hazard/forwarding logic.
package mips_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_FREEZE   = 2'b10
  } hfu_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  // The nearest producer wins: a match one stage ahead beats one two stages ahead.
  function automatic logic [1:0] pick_sel(input logic match_ex, input logic match_mem);
    if (match_ex) return FWD_MEM;
    else if (match_mem) return FWD_WB;
    else return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage instruction info in, EX operand selects and pipeline control out.
interface hazard_forward_unit_if;
  import mips_pkg::*;

  // id_valid qualifies the id_* fields in the cycle they are presented; there is
  // no ready: the producer must hold the same instruction while stall_if_id=1,
  // and an instruction is consumed on every rising edge where stall_if_id=0.
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        mem_wait;
  logic        flush;

  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        stall_if_id;
  logic        bubble_id_ex;
  logic [31:0] stall_cycles;

  hfu_state_e  dbg_state;
  slot_t       dbg_wb;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread,
           mem_wait, flush,
    input  fwd_a_sel, fwd_b_sel, stall_if_id, bubble_id_ex, stall_cycles,
           dbg_state, dbg_wb
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread,
           mem_wait, flush,
    output fwd_a_sel, fwd_b_sel, stall_if_id, bubble_id_ex, stall_cycles,
           dbg_state, dbg_wb
  );

endinterface

// File: rtl/fwd_match.sv
// Compares one source register against one shadow slot's destination.
module fwd_match
  import mips_pkg::*;
(
  input  logic       valid_i,
  input  logic       regwrite_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] src_i,
  output logic       match_o
);

  // $0 is hardwired to zero, so it never takes a forwarded value.
  assign match_o = valid_i && regwrite_i && (rd_i == src_i) && (src_i != REG_ZERO);

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage forwarding-select and load-use/freeze/flush controller for the EX muxes.
// Optional stall-cycle counter built when HAZARD_STALL_COUNT_EN is defined.
module hazard_forward_unit
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  hazard_forward_unit_if.slave hfu
);

  slot_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  hfu_state_e state_q, state_d;

  logic m_ex_a, m_ex_b, m_mem_a, m_mem_b;
  logic load_use, bubble, stall;

  fwd_match u_ex_a (.valid_i(ex_q.valid), .regwrite_i(ex_q.regwrite), .rd_i(ex_q.rd),
                    .src_i(hfu.id_rs), .match_o(m_ex_a));
  fwd_match u_ex_b (.valid_i(ex_q.valid), .regwrite_i(ex_q.regwrite), .rd_i(ex_q.rd),
                    .src_i(hfu.id_rt), .match_o(m_ex_b));
  fwd_match u_mem_a (.valid_i(mem_q.valid), .regwrite_i(mem_q.regwrite), .rd_i(mem_q.rd),
                     .src_i(hfu.id_rs), .match_o(m_mem_a));
  fwd_match u_mem_b (.valid_i(mem_q.valid), .regwrite_i(mem_q.regwrite), .rd_i(mem_q.rd),
                     .src_i(hfu.id_rt), .match_o(m_mem_b));

  // Freeze dominates everything; a flush kills the consumer so it cannot stall.
  always_comb begin
    load_use = hfu.id_valid && ex_q.memread && (m_ex_a || (hfu.id_uses_rt && m_ex_b));
    bubble   = !rst && !hfu.mem_wait && load_use && !hfu.flush;
    stall    = !rst && (hfu.mem_wait || (load_use && !hfu.flush));
  end

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (!hfu.mem_wait) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '{valid:    hfu.id_valid && !hfu.flush && !load_use,
                rd:       hfu.id_rd,
                regwrite: hfu.id_regwrite,
                memread:  hfu.id_memread};
      sel_a_d = FWD_REG;
      sel_b_d = FWD_REG;
      // Bubbles, squashed and empty slots carry register-file selects.
      if (ex_d.valid) begin
        sel_a_d = pick_sel(m_ex_a, m_mem_a);
        if (hfu.id_uses_rt) sel_b_d = pick_sel(m_ex_b, m_mem_b);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (hfu.mem_wait) begin
      state_d = ST_FREEZE;
    end else begin
      case (state_q)
        ST_RUN:      state_d = bubble ? ST_LU_STALL : ST_RUN;
        ST_LU_STALL: state_d = ST_RUN;
        ST_FREEZE:   state_d = ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= FWD_REG;
      sel_b_q <= FWD_REG;
      state_q <= ST_RUN;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      state_q <= state_d;
    end
  end

  // The stall cycle always leaves a bubble in EX, so a back-to-back load-use cannot occur.
  a_no_double_lu : assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_LU_STALL) |-> !bubble);

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb cnt_d = cnt_q + (stall ? 32'd1 : 32'd0);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign hfu.stall_cycles = cnt_q;
`else
  assign hfu.stall_cycles = '0;
`endif

  assign hfu.fwd_a_sel    = sel_a_q;
  assign hfu.fwd_b_sel    = sel_b_q;
  assign hfu.stall_if_id  = stall;
  assign hfu.bubble_id_ex = bubble;
  assign hfu.dbg_state    = state_q;
  assign hfu.dbg_wb       = wb_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed test-plan steps followed by random instruction streams for hazard_forward_unit.
module tb_hazard_forward_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_forward_unit_if hfu ();

  hazard_forward_unit dut (
    .clk (clk),
    .rst (rst),
    .hfu (hfu)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: in-flight instructions at distance 1 (EX), 2 (MEM), 3 (WB).
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } ins_t;

  ins_t        pipe[3];
  logic [1:0]  exp_a, exp_b;
  hfu_state_e  exp_st;
  logic [31:0] exp_cnt;
  logic        obs_stall, obs_bubble;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(input int d, input int src);
    return src != 0 && pipe[d].v && pipe[d].we && pipe[d].rd == src;
  endfunction

  // Youngest in-flight writer decides the source of the operand.
  function automatic logic [1:0] sel_of(input int src);
    if (writes(0, src)) return 2'b10;
    if (writes(1, src)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step(input bit v, input int rs, input int rt, input bit ur, input int rd,
                      input bit rw, input bit mr, input bit mw, input bit fl, input bit r);
    bit hz, st, bb, nv;
    @(negedge clk);
    rst             = r;
    hfu.id_valid    = v;
    hfu.id_rs       = 5'(rs);
    hfu.id_rt       = 5'(rt);
    hfu.id_uses_rt  = ur;
    hfu.id_rd       = 5'(rd);
    hfu.id_regwrite = rw;
    hfu.id_memread  = mr;
    hfu.mem_wait    = mw;
    hfu.flush       = fl;
    #1;
    hz = v && pipe[0].ld && (writes(0, rs) || (ur && writes(0, rt)));
    st = !r && (mw || (hz && !fl));
    bb = !r && !mw && hz && !fl;
    obs_stall  = hfu.stall_if_id;
    obs_bubble = hfu.bubble_id_ex;
    chk("stall_if_id", 32'(obs_stall), 32'(st));
    chk("bubble_id_ex", 32'(obs_bubble), 32'(bb));
    @(posedge clk);
    if (r) begin
      foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
      exp_a = 2'b00; exp_b = 2'b00; exp_st = ST_RUN; exp_cnt = '0;
    end else begin
`ifdef HAZARD_STALL_COUNT_EN
      if (st) exp_cnt = exp_cnt + 32'd1;
`endif
      exp_st = mw ? ST_FREEZE : ((exp_st == ST_RUN && hz && !fl) ? ST_LU_STALL : ST_RUN);
      if (!mw) begin
        nv    = v && !fl && !hz;
        exp_a = nv ? sel_of(rs) : 2'b00;
        exp_b = (nv && ur) ? sel_of(rt) : 2'b00;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = '{nv, rd, rw, mr};
      end
    end
    #1;
    chk("fwd_a_sel", 32'(hfu.fwd_a_sel), 32'(exp_a));
    chk("fwd_b_sel", 32'(hfu.fwd_b_sel), 32'(exp_b));
    chk("state", 32'(hfu.dbg_state), 32'(exp_st));
    chk("stall_cycles", hfu.stall_cycles, exp_cnt);
  endtask

  // R-type helper: rd = rs op rt.
  task automatic rtype(input int rd, input int rs, input int rt);
    step(1, rs, rt, 1, rd, 1, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] c0;
    int unsigned one_stall, four_stall;
`ifdef HAZARD_STALL_COUNT_EN
    one_stall = 1; four_stall = 4;
`else
    one_stall = 0; four_stall = 0;
`endif
    foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
    exp_a = 2'b00; exp_b = 2'b00; exp_st = ST_RUN; exp_cnt = '0;

    // Reset
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_a", 32'(hfu.fwd_a_sel), 32'd0);
    chk("rst_b", 32'(hfu.fwd_b_sel), 32'd0);
    chk("rst_state", 32'(hfu.dbg_state), 32'(ST_RUN));
    chk("rst_cnt", hfu.stall_cycles, 32'd0);
    chk("rst_stall", 32'(obs_stall), 32'd0);

    // add $3,$1,$2 ; sub $4,$3,$5
    rtype(3, 1, 2);
    rtype(4, 3, 5);
    chk("tp1_a", 32'(hfu.fwd_a_sel), 32'b10);
    chk("tp1_b", 32'(hfu.fwd_b_sel), 32'b00);

    // add $3 ; unrelated ; or $6,$7,$3
    rtype(3, 1, 2);
    rtype(11, 12, 13);
    rtype(6, 7, 3);
    chk("tp2_b_wb", 32'(hfu.fwd_b_sel), 32'b01);
    rtype(3, 1, 2);
    rtype(3, 1, 2);
    rtype(6, 7, 3);
    chk("tp2_b_mem_wins", 32'(hfu.fwd_b_sel), 32'b10);

    // lw $8,0($9) ; add $10,$8,$8
    c0 = hfu.stall_cycles;
    step(1, 9, 0, 0, 8, 1, 1, 0, 0, 0);
    rtype(10, 8, 8);
    chk("tp3_stall", 32'(obs_stall), 32'd1);
    chk("tp3_bubble", 32'(obs_bubble), 32'd1);
    rtype(10, 8, 8);
    chk("tp3_stall_gone", 32'(obs_stall), 32'd0);
    chk("tp3_a", 32'(hfu.fwd_a_sel), 32'b01);
    chk("tp3_b", 32'(hfu.fwd_b_sel), 32'b01);
    chk("tp3_cnt", hfu.stall_cycles - c0, 32'(one_stall));

    // lw $0 ; reader of $0
    step(1, 9, 0, 0, 0, 1, 1, 0, 0, 0);
    rtype(12, 0, 0);
    chk("tp4_stall", 32'(obs_stall), 32'd0);
    chk("tp4_a", 32'(hfu.fwd_a_sel), 32'b00);
    chk("tp4_b", 32'(hfu.fwd_b_sel), 32'b00);

    // mem_wait for 3 cycles during a load-use
    c0 = hfu.stall_cycles;
    step(1, 9, 0, 0, 8, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 8, 8, 1, 10, 1, 0, 1, 0, 0);
      chk("tp5_frz_stall", 32'(obs_stall), 32'd1);
      chk("tp5_frz_bubble", 32'(obs_bubble), 32'd0);
    end
    rtype(10, 8, 8);
    chk("tp5_lu_stall", 32'(obs_stall), 32'd1);
    chk("tp5_lu_bubble", 32'(obs_bubble), 32'd1);
    rtype(10, 8, 8);
    chk("tp5_a", 32'(hfu.fwd_a_sel), 32'b01);
    chk("tp5_cnt", hfu.stall_cycles - c0, 32'(four_stall));

    // flush beats load-use
    step(1, 9, 0, 0, 8, 1, 1, 0, 0, 0);
    step(1, 8, 8, 1, 10, 1, 0, 0, 1, 0);
    chk("tp6_flush_stall", 32'(obs_stall), 32'd0);
    chk("tp6_flush_a", 32'(hfu.fwd_a_sel), 32'b00);
    chk("tp6_flush_state", 32'(hfu.dbg_state), 32'(ST_RUN));
    rtype(13, 14, 15);

    // reset during LU_STALL
    step(1, 9, 0, 0, 8, 1, 1, 0, 0, 0);
    rtype(10, 8, 8);
    chk("tp6_lu_state", 32'(hfu.dbg_state), 32'(ST_LU_STALL));
    step(1, 8, 8, 1, 10, 1, 0, 0, 0, 1);
    chk("tp6_rst_state", 32'(hfu.dbg_state), 32'(ST_RUN));
    rtype(10, 8, 8);
    chk("tp6_rst_nostall", 32'(obs_stall), 32'd0);
    chk("tp6_rst_a", 32'(hfu.fwd_a_sel), 32'b00);
    chk("tp6_rst_b", 32'(hfu.fwd_b_sel), 32'b00);

    // Random instruction streams over a small register set to force matches
    for (int n = 0; n < 600; n++) begin
      bit mr;
      mr = ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 7) != 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)),
           mr || ($urandom_range(0, 3) != 0), mr,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
